// File: rtl/divisor_fp_secuencial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divisor_fp_secuencial_pkg
// Description : Shared constants, field slices and FSM state type for the
//               iterative IEEE-754 single-precision divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divisor_fp_secuencial_pkg;

    // Quotient bits produced by the restoring loop (24-bit significand + 1)
    localparam int ITER = 25;

    // IEEE-754 single-precision constants
    localparam int          BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Field slices
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_W   = MANT_MSB - MANT_LSB + 1;

    // Datapath widths: remainder carries two guard bits over the significand
    localparam int DIV_W = MANT_W + 1;
    localparam int REM_W = DIV_W + 2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/divisor_fp_secuencial_paso.sv
`default_nettype none
// ============================================================================
// Module      : paso_division
// Description : One restoring-division step. Compares the partial remainder
//               against the divisor, subtracts when possible, and returns the
//               quotient bit together with the remainder shifted left by one.
// Revision    : 1.0 - initial release
// ============================================================================
module paso_division
    import divisor_fp_secuencial_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [DIV_W-1:0] div,
    output logic             q,
    output logic [REM_W-1:0] rem_next
);

    logic [REM_W-1:0] w_div_ext;
    logic [REM_W-1:0] w_diff;
    logic [REM_W-1:0] w_keep;

    assign w_div_ext = {2'b00, div};
    assign w_diff    = rem - w_div_ext;

    // Restore (keep the old remainder) when the divisor does not fit
    always_comb begin
        q        = (rem >= w_div_ext);
        w_keep   = q ? w_diff : rem;
        rem_next = {w_keep[REM_W-2:0], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/divisor_fp_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : divisor_fp_secuencial
// Description : Iterative IEEE-754 single-precision divider. Sign by XOR,
//               exponent by difference plus bias, significand by restoring
//               division at one quotient bit per cycle. Truncating result,
//               denormals flushed to zero, fixed 27-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_fp_secuencial #(
    parameter int ITER = divisor_fp_secuencial_pkg::ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Op_A,
    input  logic [31:0] Op_B,
    input  logic        Inicio,
    output logic [31:0] Resultado,
    output logic        Listo,
    output logic        Ocupado,
    output logic        Div_Cero
);

    import divisor_fp_secuencial_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    // ------------------------------------------------------------------
    // Operand classification (denormals fold into zero)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]  w_exp_a, w_exp_b;
    logic [MANT_W-1:0] w_man_a, w_man_b;
    logic              w_zero_a, w_zero_b;
    logic              w_inf_a, w_inf_b;
    logic              w_nan_a, w_nan_b;

    assign w_exp_a  = Op_A[EXP_MSB:EXP_LSB];
    assign w_exp_b  = Op_B[EXP_MSB:EXP_LSB];
    assign w_man_a  = Op_A[MANT_MSB:MANT_LSB];
    assign w_man_b  = Op_B[MANT_MSB:MANT_LSB];
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_inf_a  = (w_exp_a == '1) && (w_man_a == '0);
    assign w_inf_b  = (w_exp_b == '1) && (w_man_b == '0);
    assign w_nan_a  = (w_exp_a == '1) && (w_man_a != '0);
    assign w_nan_b  = (w_exp_b == '1) && (w_man_b != '0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    estado_t           r_estado, w_estado_sig;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp_a, r_exp_b;
    logic              r_nan, r_zero_a, r_zero_b, r_inf_a, r_inf_b;
    logic [REM_W-1:0]  r_rem;
    logic [DIV_W-1:0]  r_div;
    logic [ITER-1:0]   r_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_res;
    logic              r_dz;

    // Single division step, reused every DIVIDE cycle
    logic             w_q;
    logic [REM_W-1:0] w_rem_sig;

    paso_division u_paso (
        .rem      (r_rem),
        .div      (r_div),
        .q        (w_q),
        .rem_next (w_rem_sig)
    );

    // ------------------------------------------------------------------
    // Normalisation and special-case resolution
    // ------------------------------------------------------------------
    logic signed [9:0] w_exp_q;
    logic [MANT_W-1:0] w_man_q;
    logic [31:0]       w_res;
    logic              w_dz;

    // Quotient lies in (0.5, 2): the top bit decides a one-place normalise
    always_comb begin
        w_exp_q = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b})
                + (r_q[ITER-1] ? $signed(10'(BIAS)) : $signed(10'(BIAS - 1)));
        w_man_q = r_q[ITER-1] ? r_q[ITER-2:1] : r_q[ITER-3:0];
    end

    // Special operands override the datapath; otherwise clamp the exponent
    always_comb begin
        w_res = '0;
        w_dz  = 1'b0;
        if (r_nan || (r_zero_a && r_zero_b) || (r_inf_a && r_inf_b)) begin
            w_res = QNAN;
        end else if (r_zero_b && !r_inf_a) begin
            w_res = {r_sign, 8'hFF, 23'd0};
            w_dz  = 1'b1;
        end else if (r_inf_a) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if (r_inf_b || r_zero_a) begin
            w_res = {r_sign, 31'd0};
        end else if (w_exp_q >= 10'sd255) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_q <= 10'sd0) begin
            w_res = {r_sign, 31'd0};
        end else begin
            w_res = {r_sign, w_exp_q[EXP_W-1:0], w_man_q};
        end
    end

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_estado <= IDLE;
        else     r_estado <= w_estado_sig;
    end

    // Next-state logic: fixed walk through the four states
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE:    if (Inicio) w_estado_sig = DIVIDE;
            DIVIDE:  if (r_cnt == '0) w_estado_sig = NORM;
            NORM:    w_estado_sig = DONE;
            DONE:    w_estado_sig = IDLE;
            default: w_estado_sig = IDLE;
        endcase
    end

    // Datapath: operand capture, restoring loop, result staging, outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_exp_a   <= '0;
            r_exp_b   <= '0;
            r_nan     <= 1'b0;
            r_zero_a  <= 1'b0;
            r_zero_b  <= 1'b0;
            r_inf_a   <= 1'b0;
            r_inf_b   <= 1'b0;
            r_rem     <= '0;
            r_div     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_res     <= '0;
            r_dz      <= 1'b0;
            Resultado <= '0;
            Listo     <= 1'b0;
            Ocupado   <= 1'b0;
            Div_Cero  <= 1'b0;
        end else begin
            Listo <= 1'b0;
            case (r_estado)
                IDLE: begin
                    Ocupado <= Inicio;
                    if (Inicio) begin
                        r_sign   <= Op_A[SIGN_BIT] ^ Op_B[SIGN_BIT];
                        r_exp_a  <= w_exp_a;
                        r_exp_b  <= w_exp_b;
                        r_nan    <= w_nan_a || w_nan_b;
                        r_zero_a <= w_zero_a;
                        r_zero_b <= w_zero_b;
                        r_inf_a  <= w_inf_a;
                        r_inf_b  <= w_inf_b;
                        r_rem    <= {2'b00, 1'b1, (w_zero_a ? '0 : w_man_a)};
                        r_div    <= {1'b1, (w_zero_b ? '0 : w_man_b)};
                        r_q      <= '0;
                        r_cnt    <= CNT_W'(ITER - 1);
                    end
                end
                DIVIDE: begin
                    r_rem <= w_rem_sig;
                    r_q   <= {r_q[ITER-2:0], w_q};
                    r_cnt <= r_cnt - 1'b1;
                end
                NORM: begin
                    r_res <= w_res;
                    r_dz  <= w_dz;
                end
                DONE: begin
                    Resultado <= r_res;
                    Div_Cero  <= r_dz;
                    Listo     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
